// File: rtl/calc_control_chain_if.sv
// ============================================================================
// Module   : calc_control_chain_if
// Purpose  : Keypad-key / datapath-command bundle for calc_control_chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_control_chain_if;
    logic       dig_in;
    logic       sub_in;
    logic       op_in;
    logic       ex_in;
    logic       bksp_in;
    logic       clr_in;
    logic       ms_in;
    logic       mr_in;
    logic       mc_in;
    logic       err_in;
    logic [2:0] led;
    logic       load_A;
    logic       load_B;
    logic       bksp_A;
    logic       bksp_B;
    logic       load_op;
    logic       execute;
    logic       load_res_A;
    logic       clear_out;
    logic       mem_store;
    logic       mem_recall_A;
    logic       mem_recall_B;
    logic       mem_clear;
    logic [1:0] display_select;
    logic       mem_valid;

    modport master (
        output dig_in, sub_in, op_in, ex_in, bksp_in, clr_in, ms_in, mr_in, mc_in, err_in,
        input  led, load_A, load_B, bksp_A, bksp_B, load_op, execute, load_res_A, clear_out,
        input  mem_store, mem_recall_A, mem_recall_B, mem_clear, display_select, mem_valid
    );

    modport slave (
        input  dig_in, sub_in, op_in, ex_in, bksp_in, clr_in, ms_in, mr_in, mc_in, err_in,
        output led, load_A, load_B, bksp_A, bksp_B, load_op, execute, load_res_A, clear_out,
        output mem_store, mem_recall_A, mem_recall_B, mem_clear, display_select, mem_valid
    );
endinterface

`default_nettype wire

// File: rtl/calc_control_chain.sv
// ============================================================================
// Module   : calc_control_chain
// Purpose  : Calculator keypad control FSM with digit limiting, result
//            chaining, error trap; memory keys when CALC_MEMORY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_control_chain #(
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    calc_control_chain_if.slave bus
);

    localparam logic [2:0] c_START   = 3'd0;
    localparam logic [2:0] c_OPA     = 3'd1;
    localparam logic [2:0] c_OPA_NEG = 3'd2;
    localparam logic [2:0] c_OPRND   = 3'd3;
    localparam logic [2:0] c_OPB     = 3'd4;
    localparam logic [2:0] c_OPB_NEG = 3'd5;
    localparam logic [2:0] c_RESULT  = 3'd6;
    localparam logic [2:0] c_ERROR   = 3'd7;

    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [2:0]       r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt_a, r_cnt_b, w_nxt_cnt_a, w_nxt_cnt_b;
    logic             w_clr, w_ex, w_op, w_sub, w_bksp, w_dig, w_hi_bk, w_err_trap;
    logic             r_load_A, r_load_B, r_bksp_A, r_bksp_B, r_load_op, r_execute, r_load_res_A, r_clear_out;
    logic             w_load_A, w_load_B, w_bksp_A, w_bksp_B, w_load_op, w_execute, w_load_res_A, w_clear_out;

    // One key per cycle: each key is masked by every higher-priority key.
    assign w_clr   = bus.clr_in;
    assign w_ex    = bus.ex_in & ~bus.clr_in;
    assign w_op    = bus.op_in & ~(bus.clr_in | bus.ex_in);
    assign w_sub   = bus.sub_in & ~(bus.clr_in | bus.ex_in | bus.op_in);
    assign w_bksp  = bus.bksp_in & ~(bus.clr_in | bus.ex_in | bus.op_in | bus.sub_in);
    assign w_hi_bk = bus.clr_in | bus.ex_in | bus.op_in | bus.sub_in | bus.bksp_in;
    assign w_dig   = bus.dig_in & ~w_hi_bk;

    // err_in is only meaningful while the execute pulse is on the bus.
    assign w_err_trap = r_execute & bus.err_in & ~w_clr;

`ifdef CALC_MEMORY_EN
    logic w_ms, w_mr, w_mc, w_a_side, w_b_side;
    logic r_mem_valid, w_nxt_mem_valid;
    logic r_mem_store, r_mem_recall_A, r_mem_recall_B, r_mem_clear;
    logic w_mem_store, w_mem_recall_A, w_mem_recall_B, w_mem_clear;

    assign w_ms     = bus.ms_in & ~(w_hi_bk | bus.dig_in);
    assign w_mr     = bus.mr_in & ~(w_hi_bk | bus.dig_in | bus.ms_in);
    assign w_mc     = bus.mc_in & ~(w_hi_bk | bus.dig_in | bus.ms_in | bus.mr_in);
    assign w_a_side = (r_state == c_START) || (r_state == c_OPA_NEG) || (r_state == c_OPA);
    assign w_b_side = (r_state == c_OPRND) || (r_state == c_OPB_NEG) || (r_state == c_OPB);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_START;
            r_cnt_a      <= '0;
            r_cnt_b      <= '0;
            r_load_A     <= 1'b0;
            r_load_B     <= 1'b0;
            r_bksp_A     <= 1'b0;
            r_bksp_B     <= 1'b0;
            r_load_op    <= 1'b0;
            r_execute    <= 1'b0;
            r_load_res_A <= 1'b0;
            r_clear_out  <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_cnt_a      <= w_nxt_cnt_a;
            r_cnt_b      <= w_nxt_cnt_b;
            r_load_A     <= w_load_A;
            r_load_B     <= w_load_B;
            r_bksp_A     <= w_bksp_A;
            r_bksp_B     <= w_bksp_B;
            r_load_op    <= w_load_op;
            r_execute    <= w_execute;
            r_load_res_A <= w_load_res_A;
            r_clear_out  <= w_clear_out;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt_a = r_cnt_a;
        w_nxt_cnt_b = r_cnt_b;
        case (r_state)
            c_START: begin
                if (w_dig)      begin w_nxt_state = c_OPA; w_nxt_cnt_a = c_ONE; end
                else if (w_sub) w_nxt_state = c_OPA_NEG;
            end
            c_OPA_NEG: begin
                if (w_dig)                begin w_nxt_state = c_OPA; w_nxt_cnt_a = c_ONE; end
                else if (w_sub || w_bksp) w_nxt_state = c_START;
            end
            c_OPA: begin
                if (w_dig && (r_cnt_a < c_MAX_CNT)) w_nxt_cnt_a = r_cnt_a + c_ONE;
                else if (w_bksp) begin
                    w_nxt_cnt_a = (r_cnt_a != '0) ? r_cnt_a - c_ONE : '0;
                    if (r_cnt_a <= c_ONE) w_nxt_state = c_START;
                end else if (w_op || w_sub) begin
                    w_nxt_state = c_OPRND;
                    w_nxt_cnt_b = '0;
                end
            end
            c_OPRND: begin
                if (w_dig)      begin w_nxt_state = c_OPB; w_nxt_cnt_b = c_ONE; end
                else if (w_sub) w_nxt_state = c_OPB_NEG;
            end
            c_OPB_NEG: begin
                if (w_dig)                begin w_nxt_state = c_OPB; w_nxt_cnt_b = c_ONE; end
                else if (w_sub || w_bksp) w_nxt_state = c_OPRND;
            end
            c_OPB: begin
                if (w_dig && (r_cnt_b < c_MAX_CNT)) w_nxt_cnt_b = r_cnt_b + c_ONE;
                else if (w_bksp) begin
                    w_nxt_cnt_b = (r_cnt_b != '0) ? r_cnt_b - c_ONE : '0;
                    if (r_cnt_b <= c_ONE) w_nxt_state = c_OPRND;
                end else if (w_ex) w_nxt_state = c_RESULT;
            end
            c_RESULT: begin
                if (w_dig) begin
                    w_nxt_state = c_OPA;
                    w_nxt_cnt_a = c_ONE;
                    w_nxt_cnt_b = '0;
                end else if (w_op || w_sub) begin
                    w_nxt_state = c_OPRND;
                    w_nxt_cnt_a = c_MAX_CNT;
                    w_nxt_cnt_b = '0;
                end
            end
            default: ;
        endcase
`ifdef CALC_MEMORY_EN
        if (w_mr && r_mem_valid && w_a_side) begin
            w_nxt_state = c_OPA;
            w_nxt_cnt_a = c_MAX_CNT;
        end else if (w_mr && r_mem_valid && w_b_side) begin
            w_nxt_state = c_OPB;
            w_nxt_cnt_b = c_MAX_CNT;
        end
`endif
        if (w_err_trap) begin
            w_nxt_state = c_ERROR;
            w_nxt_cnt_a = r_cnt_a;
            w_nxt_cnt_b = r_cnt_b;
        end
        if (w_clr) begin
            w_nxt_state = c_START;
            w_nxt_cnt_a = '0;
            w_nxt_cnt_b = '0;
        end
    end

    always_comb begin
        w_load_A     = 1'b0;
        w_load_B     = 1'b0;
        w_bksp_A     = 1'b0;
        w_bksp_B     = 1'b0;
        w_load_op    = 1'b0;
        w_execute    = 1'b0;
        w_load_res_A = 1'b0;
        w_clear_out  = 1'b0;
        case (r_state)
            c_START:   w_load_A = w_dig | w_sub;
            c_OPA_NEG: begin
                w_load_A = w_dig;
                w_bksp_A = w_sub | w_bksp;
            end
            c_OPA: begin
                w_load_A  = w_dig & (r_cnt_a < c_MAX_CNT);
                w_bksp_A  = w_bksp;
                w_load_op = w_op | w_sub;
            end
            c_OPRND:   w_load_B = w_dig | w_sub;
            c_OPB_NEG: begin
                w_load_B = w_dig;
                w_bksp_B = w_sub | w_bksp;
            end
            c_OPB: begin
                w_load_B  = w_dig & (r_cnt_b < c_MAX_CNT);
                w_bksp_B  = w_bksp;
                w_execute = w_ex;
            end
            c_RESULT: begin
                w_clear_out  = w_dig;
                w_load_A     = w_dig;
                w_load_res_A = w_op | w_sub;
                w_load_op    = w_op | w_sub;
            end
            default: ;
        endcase
        if (w_err_trap) begin
            w_load_A     = 1'b0;
            w_clear_out  = 1'b0;
            w_load_res_A = 1'b0;
            w_load_op    = 1'b0;
        end
        if (w_clr) w_clear_out = 1'b1;
    end

    always_comb begin
        case (r_state)
            c_START, c_OPA, c_OPA_NEG:   bus.display_select = 2'b00;
            c_OPRND, c_OPB, c_OPB_NEG:   bus.display_select = 2'b01;
            c_RESULT:                    bus.display_select = 2'b10;
            default:                     bus.display_select = 2'b11;
        endcase
    end

    assign bus.led        = r_state;
    assign bus.load_A     = r_load_A;
    assign bus.load_B     = r_load_B;
    assign bus.bksp_A     = r_bksp_A;
    assign bus.bksp_B     = r_bksp_B;
    assign bus.load_op    = r_load_op;
    assign bus.execute    = r_execute;
    assign bus.load_res_A = r_load_res_A;
    assign bus.clear_out  = r_clear_out;

`ifdef CALC_MEMORY_EN
    // Memory keys never act in ERROR; mem_valid deliberately survives clr.
    always_comb begin
        w_nxt_mem_valid = r_mem_valid;
        w_mem_store     = 1'b0;
        w_mem_recall_A  = 1'b0;
        w_mem_recall_B  = 1'b0;
        w_mem_clear     = 1'b0;
        if (!w_err_trap) begin
            if (w_ms && ((r_state == c_OPA) || (r_state == c_OPB) || (r_state == c_RESULT))) begin
                w_mem_store     = 1'b1;
                w_nxt_mem_valid = 1'b1;
            end
            w_mem_recall_A = w_mr & r_mem_valid & w_a_side;
            w_mem_recall_B = w_mr & r_mem_valid & w_b_side;
            if (w_mc && (r_state != c_ERROR)) begin
                w_mem_clear     = 1'b1;
                w_nxt_mem_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_valid    <= 1'b0;
            r_mem_store    <= 1'b0;
            r_mem_recall_A <= 1'b0;
            r_mem_recall_B <= 1'b0;
            r_mem_clear    <= 1'b0;
        end else begin
            r_mem_valid    <= w_nxt_mem_valid;
            r_mem_store    <= w_mem_store;
            r_mem_recall_A <= w_mem_recall_A;
            r_mem_recall_B <= w_mem_recall_B;
            r_mem_clear    <= w_mem_clear;
        end
    end

    assign bus.mem_valid    = r_mem_valid;
    assign bus.mem_store    = r_mem_store;
    assign bus.mem_recall_A = r_mem_recall_A;
    assign bus.mem_recall_B = r_mem_recall_B;
    assign bus.mem_clear    = r_mem_clear;
`else
    logic w_unused_mem;
    assign w_unused_mem     = bus.ms_in | bus.mr_in | bus.mc_in;
    assign bus.mem_valid    = 1'b0;
    assign bus.mem_store    = 1'b0;
    assign bus.mem_recall_A = 1'b0;
    assign bus.mem_recall_B = 1'b0;
    assign bus.mem_clear    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_calc_control_chain.sv
// ============================================================================
// Module   : tb_calc_control_chain
// Purpose  : Directed self-checking bench for calc_control_chain (MAX_DIGITS=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_control_chain;

    localparam logic [9:0] K_NONE = 10'h000;
    localparam logic [9:0] K_CLR  = 10'h200;
    localparam logic [9:0] K_EX   = 10'h100;
    localparam logic [9:0] K_OP   = 10'h080;
    localparam logic [9:0] K_SUB  = 10'h040;
    localparam logic [9:0] K_BK   = 10'h020;
    localparam logic [9:0] K_DIG  = 10'h010;
    localparam logic [9:0] K_MS   = 10'h008;
    localparam logic [9:0] K_MR   = 10'h004;
    localparam logic [9:0] K_MC   = 10'h002;
    localparam logic [9:0] K_ERR  = 10'h001;

    localparam logic [11:0] P_NONE = 12'h000;
    localparam logic [11:0] P_LA   = 12'h800;
    localparam logic [11:0] P_LB   = 12'h400;
    localparam logic [11:0] P_BA   = 12'h200;
    localparam logic [11:0] P_BB   = 12'h100;
    localparam logic [11:0] P_LOP  = 12'h080;
    localparam logic [11:0] P_EX   = 12'h040;
    localparam logic [11:0] P_LRA  = 12'h020;
    localparam logic [11:0] P_CLR  = 12'h010;
    localparam logic [11:0] P_MS   = 12'h008;
    localparam logic [11:0] P_MRA  = 12'h004;
    localparam logic [11:0] P_MRB  = 12'h002;
    localparam logic [11:0] P_MC   = 12'h001;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    logic [9:0]  kq[$];
    logic [17:0] eq[$];

    calc_control_chain_if bus ();

    calc_control_chain #(.MAX_DIGITS(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed word: {mem_valid, led, display_select, 12 command pulses}
    function automatic logic [17:0] obs();
        return {bus.mem_valid, bus.led, bus.display_select,
                bus.load_A, bus.load_B, bus.bksp_A, bus.bksp_B, bus.load_op, bus.execute,
                bus.load_res_A, bus.clear_out, bus.mem_store, bus.mem_recall_A,
                bus.mem_recall_B, bus.mem_clear};
    endfunction

    function automatic logic [17:0] exp_word(input logic mv, input logic [2:0] led,
                                             input logic [1:0] ds, input logic [11:0] p);
        return {mv, led, ds, p};
    endfunction

    task automatic set_keys(input logic [9:0] k);
        {bus.clr_in, bus.ex_in, bus.op_in, bus.sub_in, bus.bksp_in,
         bus.dig_in, bus.ms_in, bus.mr_in, bus.mc_in, bus.err_in} = k;
    endtask

    // Present keys for one rising edge; return 1 time unit after that edge.
    task automatic apply(input logic [9:0] k);
        @(negedge clock);
        set_keys(k);
        @(posedge clock);
        #1;
        set_keys(K_NONE);
    endtask

    task automatic add(input logic [9:0] k, input logic [17:0] e);
        kq.push_back(k);
        eq.push_back(e);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        set_keys(K_NONE);
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (obs() !== exp_word(1'b0, 3'd0, 2'b00, P_NONE)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs(), exp_word(1'b0, 3'd0, 2'b00, P_NONE));
        end
        reset_n = 1'b1;
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_OP,  exp_word(1'b0, 3'd3, 2'b01, P_LOP));
        add(K_DIG, exp_word(1'b0, 3'd4, 2'b01, P_LB));
        add(K_DIG, exp_word(1'b0, 3'd4, 2'b01, P_LB));
        foreach (kq[i]) begin
            apply(kq[i]);
            checks++;
            if (obs() !== eq[i]) begin
                errors++;
                $display("FAIL reset_setup step %0d: got %h expected %h", i, obs(), eq[i]);
            end
        end
        kq.delete();
        eq.delete();
        // Mid-cycle async reset while load_B is pulsing in OPB with cnt_b=2.
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== exp_word(1'b0, 3'd0, 2'b00, P_NONE)) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", obs(), exp_word(1'b0, 3'd0, 2'b00, P_NONE));
        end
        @(negedge clock);
        reset_n = 1'b1;
        apply(K_DIG);
        checks++;
        if (obs() !== exp_word(1'b0, 3'd1, 2'b00, P_LA)) begin
            errors++;
            $display("FAIL reset_release_dig: got %h expected %h", obs(), exp_word(1'b0, 3'd1, 2'b00, P_LA));
        end
    endtask

    task automatic test_digit_limit();
        add(K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
        for (int n = 0; n < 4; n++) add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_NONE));
        for (int n = 0; n < 3; n++) add(K_BK, exp_word(1'b0, 3'd1, 2'b00, P_BA));
        add(K_BK, exp_word(1'b0, 3'd0, 2'b00, P_BA));
        add(K_BK, exp_word(1'b0, 3'd0, 2'b00, P_NONE));
        foreach (kq[i]) begin
            apply(kq[i]);
            checks++;
            if (obs() !== eq[i]) begin
                errors++;
                $display("FAIL digit_limit step %0d: got %h expected %h", i, obs(), eq[i]);
            end
        end
        kq.delete();
        eq.delete();
    endtask

    task automatic test_negative();
        add(K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
        add(K_SUB, exp_word(1'b0, 3'd2, 2'b00, P_LA));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_BK,  exp_word(1'b0, 3'd0, 2'b00, P_BA));
        add(K_BK,  exp_word(1'b0, 3'd0, 2'b00, P_NONE));
        add(K_SUB, exp_word(1'b0, 3'd2, 2'b00, P_LA));
        add(K_SUB, exp_word(1'b0, 3'd0, 2'b00, P_BA));
        add(K_SUB, exp_word(1'b0, 3'd2, 2'b00, P_LA));
        add(K_BK,  exp_word(1'b0, 3'd0, 2'b00, P_BA));
        foreach (kq[i]) begin
            apply(kq[i]);
            checks++;
            if (obs() !== eq[i]) begin
                errors++;
                $display("FAIL negative step %0d: got %h expected %h", i, obs(), eq[i]);
            end
        end
        kq.delete();
        eq.delete();
    endtask

    task automatic test_chain();
        add(K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_OP,  exp_word(1'b0, 3'd3, 2'b01, P_LOP));
        add(K_DIG, exp_word(1'b0, 3'd4, 2'b01, P_LB));
        add(K_OP,  exp_word(1'b0, 3'd4, 2'b01, P_NONE));
        add(K_SUB, exp_word(1'b0, 3'd4, 2'b01, P_NONE));
        add(K_EX,  exp_word(1'b0, 3'd6, 2'b10, P_EX));
        add(K_EX,  exp_word(1'b0, 3'd6, 2'b10, P_NONE));
        add(K_BK,  exp_word(1'b0, 3'd6, 2'b10, P_NONE));
        add(K_OP,  exp_word(1'b0, 3'd3, 2'b01, P_LRA | P_LOP));
        add(K_SUB, exp_word(1'b0, 3'd5, 2'b01, P_LB));
        add(K_BK,  exp_word(1'b0, 3'd3, 2'b01, P_BB));
        add(K_DIG, exp_word(1'b0, 3'd4, 2'b01, P_LB));
        add(K_BK,  exp_word(1'b0, 3'd3, 2'b01, P_BB));
        add(K_DIG, exp_word(1'b0, 3'd4, 2'b01, P_LB));
        add(K_EX,  exp_word(1'b0, 3'd6, 2'b10, P_EX));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_CLR | P_LA));
        foreach (kq[i]) begin
            apply(kq[i]);
            checks++;
            if (obs() !== eq[i]) begin
                errors++;
                $display("FAIL chain step %0d: got %h expected %h", i, obs(), eq[i]);
            end
        end
        kq.delete();
        eq.delete();
    endtask

    task automatic test_error();
        add(K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
        add(K_ERR, exp_word(1'b0, 3'd0, 2'b00, P_NONE));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_OP,  exp_word(1'b0, 3'd3, 2'b01, P_LOP));
        add(K_DIG, exp_word(1'b0, 3'd4, 2'b01, P_LB));
        add(K_EX,  exp_word(1'b0, 3'd6, 2'b10, P_EX));
        add(K_ERR, exp_word(1'b0, 3'd7, 2'b11, P_NONE));
        add(K_DIG, exp_word(1'b0, 3'd7, 2'b11, P_NONE));
        add(K_EX,  exp_word(1'b0, 3'd7, 2'b11, P_NONE));
        add(K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_OP,  exp_word(1'b0, 3'd3, 2'b01, P_LOP));
        add(K_DIG, exp_word(1'b0, 3'd4, 2'b01, P_LB));
        add(K_EX,  exp_word(1'b0, 3'd6, 2'b10, P_EX));
        add(K_DIG | K_ERR, exp_word(1'b0, 3'd7, 2'b11, P_NONE));
        add(K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
        foreach (kq[i]) begin
            apply(kq[i]);
            checks++;
            if (obs() !== eq[i]) begin
                errors++;
                $display("FAIL error_trap step %0d: got %h expected %h", i, obs(), eq[i]);
            end
        end
        kq.delete();
        eq.delete();
    endtask

    task automatic test_priority();
        add(K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_DIG | K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_OP | K_DIG, exp_word(1'b0, 3'd3, 2'b01, P_LOP));
        add(K_EX | K_DIG, exp_word(1'b0, 3'd3, 2'b01, P_NONE));
        add(K_SUB | K_BK | K_DIG, exp_word(1'b0, 3'd5, 2'b01, P_LB));
        add(K_BK | K_DIG, exp_word(1'b0, 3'd3, 2'b01, P_BB));
        foreach (kq[i]) begin
            apply(kq[i]);
            checks++;
            if (obs() !== eq[i]) begin
                errors++;
                $display("FAIL priority step %0d: got %h expected %h", i, obs(), eq[i]);
            end
        end
        kq.delete();
        eq.delete();
    endtask

    task automatic test_memory();
        add(K_CLR, exp_word(1'b0, 3'd0, 2'b00, P_CLR));
`ifdef CALC_MEMORY_EN
        add(K_MR,  exp_word(1'b0, 3'd0, 2'b00, P_NONE));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_MS,  exp_word(1'b1, 3'd1, 2'b00, P_MS));
        add(K_CLR, exp_word(1'b1, 3'd0, 2'b00, P_CLR));
        add(K_MR,  exp_word(1'b1, 3'd1, 2'b00, P_MRA));
        add(K_DIG, exp_word(1'b1, 3'd1, 2'b00, P_NONE));
        add(K_OP,  exp_word(1'b1, 3'd3, 2'b01, P_LOP));
        add(K_MR,  exp_word(1'b1, 3'd4, 2'b01, P_MRB));
        add(K_MC,  exp_word(1'b0, 3'd4, 2'b01, P_MC));
        add(K_DIG, exp_word(1'b0, 3'd4, 2'b01, P_NONE));
        add(K_MR,  exp_word(1'b0, 3'd4, 2'b01, P_NONE));
`else
        add(K_MR,  exp_word(1'b0, 3'd0, 2'b00, P_NONE));
        add(K_DIG, exp_word(1'b0, 3'd1, 2'b00, P_LA));
        add(K_MS,  exp_word(1'b0, 3'd1, 2'b00, P_NONE));
        add(K_MR,  exp_word(1'b0, 3'd1, 2'b00, P_NONE));
        add(K_MC,  exp_word(1'b0, 3'd1, 2'b00, P_NONE));
`endif
        add(K_CLR, exp_word(1'b0 | bus.mem_valid & 1'b0, 3'd0, 2'b00, P_CLR));
        foreach (kq[i]) begin
            apply(kq[i]);
            checks++;
            if (obs() !== eq[i]) begin
                errors++;
                $display("FAIL memory step %0d: got %h expected %h", i, obs(), eq[i]);
            end
        end
        kq.delete();
        eq.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_digit_limit();
        test_negative();
        test_chain();
        test_error();
        test_priority();
        test_memory();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
